// File: rtl/md_link_pkg.sv
// Shared constants, state encodings and update-frame byte mux for the
// market-data UART link endpoint.
package md_link_pkg;

  localparam logic [7:0] UPD_START = 8'hF0;
  localparam logic [7:0] UPD_STOP  = 8'h0F;
  localparam logic [7:0] ORD_START = 8'h80;
  localparam logic [7:0] ORD_STOP  = 8'h01;
  localparam int         UPD_LEN   = 19;
  localparam int         ORD_LEN   = 8;

  // Each 32-bit payload word leaves as bytes 2,3,0,1.
  localparam logic [1:0] LANE_ORDER [4] = '{2'd2, 2'd3, 2'd0, 2'd1};

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP,
    TX_WAIT_REPLY
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_B1,
    RX_B2,
    RX_B3,
    RX_B4,
    RX_B5,
    RX_B6,
    RX_STOP
  } rx_state_e;

  // payload[0..3] = buyprice, sellprice, buyvol, sellvol
  function automatic logic [7:0] upd_frame_byte(input logic [4:0]       idx,
                                                input logic [7:0]       addr,
                                                input logic [3:0][31:0] payload);
    logic [3:0] off;
    logic [1:0] lane;
    off  = 4'(idx - 5'd2);
    lane = LANE_ORDER[off[1:0]];
    if (idx == 5'd0)
      return UPD_START;
    else if (idx == 5'd1)
      return addr;
    else if (idx == 5'(UPD_LEN - 1))
      return UPD_STOP;
    else
      return payload[off[3:2]][{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/md_feed_endpoint_if.sv
// Update, UART byte and decoded-order signals of the feed endpoint.
interface md_feed_endpoint_if;

  logic        upd_valid;
  logic        upd_ready;
  logic [7:0]  upd_addr;
  logic [31:0] upd_buyprice;
  logic [31:0] upd_sellprice;
  logic [31:0] upd_buyvol;
  logic [31:0] upd_sellvol;
  logic [7:0]  byte_tx_data;
  logic        byte_tx_valid;
  logic        byte_tx_ready;
  logic [7:0]  byte_rx_data;
  logic        byte_rx_dv;
  logic        ord_dv;
  logic [7:0]  ord_addr;
  logic [7:0]  ord_buysell;
  logic [31:0] ord_timestamp;
  logic        frame_err;
  logic        timeout;
  logic        busy;

  modport slave (
    input  upd_valid, upd_addr, upd_buyprice, upd_sellprice, upd_buyvol, upd_sellvol,
    input  byte_tx_ready, byte_rx_data, byte_rx_dv,
    output upd_ready, byte_tx_data, byte_tx_valid,
    output ord_dv, ord_addr, ord_buysell, ord_timestamp, frame_err, timeout, busy
  );

  modport master (
    output upd_valid, upd_addr, upd_buyprice, upd_sellprice, upd_buyvol, upd_sellvol,
    output byte_tx_ready, byte_rx_data, byte_rx_dv,
    input  upd_ready, byte_tx_data, byte_tx_valid,
    input  ord_dv, ord_addr, ord_buysell, ord_timestamp, frame_err, timeout, busy
  );

endinterface

// File: rtl/md_ord_parser.sv
// Free-running parser for the 8-byte order frame; reports the decoded fields
// plus a one-cycle good-stop or bad-stop indication on the stop byte's strobe.
module md_ord_parser
  import md_link_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_dv_i,
  output logic [7:0]  addr_o,
  output logic [7:0]  buysell_o,
  output logic [31:0] timestamp_o,
  output logic        frame_done_o,
  output logic        stop_err_o
);

  rx_state_e   state_q, state_d;
  logic [7:0]  addr_q, buysell_q;
  logic [31:0] ts_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RX_HUNT;
      addr_q    <= '0;
      buysell_q <= '0;
      ts_q      <= '0;
    end else begin
      state_q <= state_d;
      if (rx_dv_i) begin
        case (state_q)
          RX_B1:   addr_q        <= rx_data_i;
          RX_B2:   buysell_q     <= rx_data_i;
          RX_B3:   ts_q[7:0]     <= rx_data_i;
          RX_B4:   ts_q[15:8]    <= rx_data_i;
          RX_B5:   ts_q[23:16]   <= rx_data_i;
          RX_B6:   ts_q[31:24]   <= rx_data_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_done_o = 1'b0;
    stop_err_o   = 1'b0;
    if (rx_dv_i) begin
      case (state_q)
        RX_HUNT: if (rx_data_i == ORD_START) state_d = RX_B1;
        RX_STOP: begin
          state_d = RX_HUNT;
          if (rx_data_i == ORD_STOP) frame_done_o = 1'b1;
          else                       stop_err_o   = 1'b1;
        end
        default: state_d = rx_state_e'(state_q + 3'd1);
      endcase
    end
  end

  assign addr_o      = addr_q;
  assign buysell_o   = buysell_q;
  assign timestamp_o = ts_q;

endmodule

// File: rtl/md_feed_endpoint.sv
// Host-side market-data endpoint: sends one 19-byte update frame, then waits
// for the matching 8-byte order reply or a reply timeout before the next one.
module md_feed_endpoint
  import md_link_pkg::*;
#(
  parameter int REPLY_TIMEOUT = 1000000,
  parameter int BYTE_GAP      = 0
) (
  input  logic              clk,
  input  logic              reset,
  md_feed_endpoint_if.slave link
);

  localparam int               TMR_W    = $clog2(REPLY_TIMEOUT + 1);
  localparam int               GAP_W    = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REPLY_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
  localparam logic [4:0]       IDX_LAST = 5'(UPD_LEN - 1);

  tx_state_e        state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       out_addr_q;
  logic [3:0][31:0] payload_q;
  logic             upd_ready_q, ord_dv_q, frame_err_q, timeout_q;
  logic [7:0]       ord_addr_q, ord_buysell_q;
  logic [31:0]      ord_ts_q;

  logic [7:0]  p_addr, p_buysell;
  logic [31:0] p_ts;
  logic        p_done, p_stop_err;
  logic        accept, tx_fire, reply_ok, timeout_hit;

  md_ord_parser u_parser (
    .clk          (clk),
    .reset        (reset),
    .rx_data_i    (link.byte_rx_data),
    .rx_dv_i      (link.byte_rx_dv),
    .addr_o       (p_addr),
    .buysell_o    (p_buysell),
    .timestamp_o  (p_ts),
    .frame_done_o (p_done),
    .stop_err_o   (p_stop_err)
  );

  assign accept      = (state_q == TX_IDLE) && upd_ready_q && link.upd_valid;
  assign tx_fire     = (state_q == TX_SEND) && link.byte_tx_ready;
  assign reply_ok    = p_done && (state_q == TX_WAIT_REPLY) && (p_addr == out_addr_q);
  // A reply completing on the last timer cycle takes priority over the timeout.
  assign timeout_hit = (state_q == TX_WAIT_REPLY) && (timer_q == TMR_LAST) && !reply_ok;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    case (state_q)
      TX_IDLE: if (accept) begin
        state_d = TX_SEND;
        idx_d   = '0;
      end
      TX_SEND: if (tx_fire) begin
        if (idx_q == IDX_LAST) begin
          state_d = TX_WAIT_REPLY;
          timer_d = '0;
        end else begin
          idx_d = idx_q + 5'd1;
          if (BYTE_GAP > 0) begin
            state_d = TX_GAP;
            gap_d   = '0;
          end
        end
      end
      TX_GAP: begin
        if (gap_q == GAP_LAST) state_d = TX_SEND;
        else                   gap_d   = gap_q + 1'b1;
      end
      TX_WAIT_REPLY: begin
        timer_d = timer_q + 1'b1;
        if (reply_ok || timeout_hit) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= TX_IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      gap_q         <= '0;
      out_addr_q    <= '0;
      payload_q     <= '0;
      upd_ready_q   <= 1'b0;
      ord_dv_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
      ord_addr_q    <= '0;
      ord_buysell_q <= '0;
      ord_ts_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      upd_ready_q <= (state_d == TX_IDLE);
      ord_dv_q    <= reply_ok;
      frame_err_q <= p_stop_err || (p_done && !reply_ok);
      timeout_q   <= timeout_hit;
      if (accept) begin
        out_addr_q <= link.upd_addr;
        payload_q  <= {link.upd_sellvol, link.upd_buyvol, link.upd_sellprice, link.upd_buyprice};
      end
      if (reply_ok) begin
        ord_addr_q    <= p_addr;
        ord_buysell_q <= p_buysell;
        ord_ts_q      <= p_ts;
      end
    end
  end

  assign link.upd_ready     = upd_ready_q;
  assign link.byte_tx_valid = (state_q == TX_SEND);
  assign link.byte_tx_data  = (state_q == TX_SEND) ? upd_frame_byte(idx_q, out_addr_q, payload_q) : 8'h00;
  assign link.busy          = (state_q != TX_IDLE);
  assign link.ord_dv        = ord_dv_q;
  assign link.ord_addr      = ord_addr_q;
  assign link.ord_buysell   = ord_buysell_q;
  assign link.ord_timestamp = ord_ts_q;
  assign link.frame_err     = frame_err_q;
  assign link.timeout       = timeout_q;

endmodule

// File: tb/tb_md_feed_endpoint.sv
// Directed bench for md_feed_endpoint: update serialization, reply decoding,
// error frames, reply timeout and mid-frame reset.
module tb_md_feed_endpoint;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_feed_endpoint_if link();

  md_feed_endpoint #(
    .REPLY_TIMEOUT (50),
    .BYTE_GAP      (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .link  (link)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int since        = 0;

  logic [7:0] exp_frame [19] = '{8'hF0, 8'h05,
                                 8'h22, 8'h11, 8'h44, 8'h33,
                                 8'h66, 8'h55, 8'h88, 8'h77,
                                 8'h00, 8'h00, 8'h0A, 8'h00,
                                 8'h00, 8'h00, 8'hFF, 8'h00,
                                 8'h0F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    since++;
  endtask

  task automatic offer(input string tag);
    check({tag, "_ready_before"}, 32'(link.upd_ready), 32'd1);
    link.upd_valid     = 1'b1;
    link.upd_addr      = 8'h05;
    link.upd_buyprice  = 32'h11223344;
    link.upd_sellprice = 32'h55667788;
    link.upd_buyvol    = 32'h0000000A;
    link.upd_sellvol   = 32'h000000FF;
    tick();
    link.upd_valid = 1'b0;
    check({tag, "_busy"}, 32'(link.busy), 32'd1);
    check({tag, "_ready_low"}, 32'(link.upd_ready), 32'd0);
  endtask

  // mode 0: ready every cycle; mode 1: ready one cycle in three
  task automatic collect(input string tag, input int mode);
    int         n       = 0;
    int         cyc     = 0;
    logic [7:0] held    = 8'h00;
    logic       stalled = 1'b0;
    while (n < 19 && cyc < 400) begin
      link.byte_tx_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
      if (link.byte_tx_valid) begin
        if (stalled) check($sformatf("%s_stable%0d", tag, n), 32'(link.byte_tx_data), 32'(held));
        if (link.byte_tx_ready) begin
          check($sformatf("%s_byte%0d", tag, n), 32'(link.byte_tx_data), 32'(exp_frame[n]));
          n++;
          stalled = 1'b0;
        end else begin
          held    = link.byte_tx_data;
          stalled = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    check({tag, "_byte_count"}, 32'(n), 32'd19);
    since = 0;
  endtask

  task automatic send_rx(input logic [71:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      link.byte_rx_data = seq[8*i +: 8];
      link.byte_rx_dv   = 1'b1;
      tick();
      link.byte_rx_dv   = 1'b0;
    end
  endtask

  initial begin
    reset              = 1'b1;
    link.upd_valid     = 1'b0;
    link.upd_addr      = '0;
    link.upd_buyprice  = '0;
    link.upd_sellprice = '0;
    link.upd_buyvol    = '0;
    link.upd_sellvol   = '0;
    link.byte_tx_ready = 1'b0;
    link.byte_rx_data  = '0;
    link.byte_rx_dv    = 1'b0;
    tick();
    tick();
    check("rst_tx_valid", 32'(link.byte_tx_valid), 32'd0);
    check("rst_tx_data", 32'(link.byte_tx_data), 32'd0);
    check("rst_busy", 32'(link.busy), 32'd0);
    check("rst_upd_ready", 32'(link.upd_ready), 32'd0);
    check("rst_ord_dv", 32'(link.ord_dv), 32'd0);
    check("rst_ord_ts", link.ord_timestamp, 32'd0);
    check("rst_frame_err", 32'(link.frame_err), 32'd0);
    check("rst_timeout", 32'(link.timeout), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(link.upd_ready), 32'd1);

    // update with the UART always ready, then a good reply
    link.byte_tx_ready = 1'b1;
    offer("u1");
    collect("u1", 0);
    check("u1_wait_busy", 32'(link.busy), 32'd1);
    send_rx(72'h80_05_01_EF_BE_AD_DE_01, 8);
    check("r1_ord_dv", 32'(link.ord_dv), 32'd1);
    check("r1_ord_addr", 32'(link.ord_addr), 32'h05);
    check("r1_ord_buysell", 32'(link.ord_buysell), 32'h01);
    check("r1_ord_ts", link.ord_timestamp, 32'hDEADBEEF);
    check("r1_frame_err", 32'(link.frame_err), 32'd0);
    check("r1_busy", 32'(link.busy), 32'd0);
    check("r1_upd_ready", 32'(link.upd_ready), 32'd1);
    tick();
    check("r1_ord_dv_pulse", 32'(link.ord_dv), 32'd0);
    check("r1_ord_addr_hold", 32'(link.ord_addr), 32'h05);

    // same update with a stalling UART, then bad replies and a timeout
    offer("u2");
    collect("u2", 1);
    send_rx(72'h80_05_01_00_00_00_00_07, 8);
    check("bad_stop_err", 32'(link.frame_err), 32'd1);
    check("bad_stop_ord_dv", 32'(link.ord_dv), 32'd0);
    check("bad_stop_busy", 32'(link.busy), 32'd1);
    tick();
    check("bad_stop_err_pulse", 32'(link.frame_err), 32'd0);
    send_rx(72'h13_80_06_02_11_22_33_44_01, 9);
    check("mismatch_err", 32'(link.frame_err), 32'd1);
    check("mismatch_ord_dv", 32'(link.ord_dv), 32'd0);
    check("mismatch_busy", 32'(link.busy), 32'd1);
    check("mismatch_ord_addr", 32'(link.ord_addr), 32'h05);
    check("mismatch_ord_ts", link.ord_timestamp, 32'hDEADBEEF);
    while (since < 49) tick();
    check("tmo_not_yet", 32'(link.timeout), 32'd0);
    check("tmo_busy_before", 32'(link.busy), 32'd1);
    tick();
    check("tmo_pulse", 32'(link.timeout), 32'd1);
    check("tmo_busy_after", 32'(link.busy), 32'd0);
    check("tmo_upd_ready", 32'(link.upd_ready), 32'd1);
    tick();
    check("tmo_pulse_end", 32'(link.timeout), 32'd0);

    // good-looking reply while nothing is outstanding
    send_rx(72'h80_05_01_EF_BE_AD_DE_01, 8);
    check("unsol_err", 32'(link.frame_err), 32'd1);
    check("unsol_ord_dv", 32'(link.ord_dv), 32'd0);
    tick();

    // reply stop byte lands on the timeout cycle
    offer("u3");
    collect("u3", 0);
    while (since < 42) tick();
    send_rx(72'h80_05_02_78_56_34_12_01, 8);
    check("race_ord_dv", 32'(link.ord_dv), 32'd1);
    check("race_timeout", 32'(link.timeout), 32'd0);
    check("race_ord_buysell", 32'(link.ord_buysell), 32'h02);
    check("race_ord_ts", link.ord_timestamp, 32'h12345678);
    check("race_busy", 32'(link.busy), 32'd0);
    tick();
    check("race_timeout_after", 32'(link.timeout), 32'd0);

    // reset in the middle of a frame
    offer("u4");
    for (int i = 0; i < 7; i++) tick();
    check("mid_byte7", 32'(link.byte_tx_data), 32'h55);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(link.byte_tx_valid), 32'd0);
    check("mid_rst_busy", 32'(link.busy), 32'd0);
    reset = 1'b0;
    tick();
    check("mid_rst_ready", 32'(link.upd_ready), 32'd1);
    offer("u5");
    check("restart_valid", 32'(link.byte_tx_valid), 32'd1);
    check("restart_byte0", 32'(link.byte_tx_data), 32'hF0);
    tick();
    check("restart_byte1", 32'(link.byte_tx_data), 32'h05);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
